// File: rtl/keypad_hex_entry.sv
// Purpose : scans a 4x4 active-low keypad, debounces presses and shifts each accepted hex code into an 8-digit number.
// Latency : press to keyValid = 2 (sync) + remaining column slot + DEBOUNCE_CYC cycles; outputs are registered.
// Backpr. : none. The scan is free-running and keyValid is a one-cycle pulse with no ready; the consumer must take it.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   rowIn[3:0]   keypad rows, active-low, asynchronous (2-flop synchronized)
//   colOut[3:0]  keypad columns, active-low, one column low at a time
//   clr          synchronous clear of number (wins over a same-cycle accept)
//   number[31:0] entered value, newest digit in [3:0]
//   keyCode[3:0] code of the last accepted key (4*row + col)
//   keyValid     one-cycle pulse per accepted key
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat every REPEAT_CYC cycles while held).

module keypad_hex_entry #(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CYC = 20000,
   parameter int REPEAT_CYC   = 5000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  rowIn,
   output logic [3:0]  colOut,
   input  logic        clr,
   output logic [31:0] number,
   output logic [3:0]  keyCode,
   output logic        keyValid
);

   // Elaboration-time guard on parameter ranges.
   generate
      if (SCAN_DIV < 4 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
         $error("keypad_hex_entry: parameter out of range");
      end
   endgenerate

   localparam int SW = $clog2(SCAN_DIV);
   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2
   } state_t;

   // Row synchronizer; idle value is all-high so reset looks like "no key".
   logic [3:0] row_meta;
   logic [3:0] row_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'hF;
         row_s    <= 4'hF;
      end else begin
         row_meta <= rowIn;
         row_s    <= row_meta;
      end
   end

   state_t          state, state_nxt;
   logic [1:0]      col_idx, col_nxt;
   logic [SW-1:0]   slot_cnt, slot_nxt;
   logic [DW-1:0]   cnt, cnt_nxt;      // press debounce / release debounce counter
   logic [3:0]      pat, pat_nxt;      // row pattern latched at detection
   logic [1:0]      row_idx, ridx_nxt;
   logic [1:0]      low_row;
   logic [3:0]      code;
   logic            accept;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYC);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
   logic [RW-1:0]   rep_cnt, rep_nxt;
`endif

   // Lowest-numbered low row wins when several rows are pressed.
   always_comb begin
      low_row = 2'd3;
      if (!row_s[0])      low_row = 2'd0;
      else if (!row_s[1]) low_row = 2'd1;
      else if (!row_s[2]) low_row = 2'd2;
   end

   assign code   = {row_idx, col_idx};
   assign colOut = ~(4'b0001 << col_idx);

   always_comb begin
      state_nxt = state;
      col_nxt   = col_idx;
      slot_nxt  = slot_cnt;
      cnt_nxt   = cnt;
      pat_nxt   = pat;
      ridx_nxt  = row_idx;
      accept    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_nxt   = '0;
`endif
      case (state)
         ST_SCAN: begin
            if (slot_cnt == SLOT_LAST) begin
               // Rows are only trusted on the last slot cycle, when the
               // synchronizer has settled on this column's response.
               slot_nxt = '0;
               if (row_s != 4'hF) begin
                  state_nxt = ST_DEBOUNCE;
                  pat_nxt   = row_s;
                  ridx_nxt  = low_row;
                  cnt_nxt   = '0;
               end else begin
                  col_nxt = col_idx + 2'd1;
               end
            end else begin
               slot_nxt = slot_cnt + 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (row_s == pat) begin
               if (cnt == DEB_LAST) begin
                  accept    = 1'b1;
                  state_nxt = ST_HELD;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end else begin
               state_nxt = ST_SCAN;
               cnt_nxt   = '0;
               col_nxt   = col_idx + 2'd1;
            end
         end
         ST_HELD: begin
            // Counts consecutive all-released cycles; any low row restarts it,
            // so a second key pressed here is ignored until full release.
            if (row_s == 4'hF) begin
               if (cnt == DEB_LAST) begin
                  state_nxt = ST_SCAN;
                  cnt_nxt   = '0;
                  col_nxt   = col_idx + 2'd1;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end else begin
               cnt_nxt = '0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (row_s == pat) begin
               if (rep_cnt == REP_LAST) begin
                  accept  = 1'b1;
                  rep_nxt = '0;
               end else begin
                  rep_nxt = rep_cnt + 1'b1;
               end
            end
`endif
         end
         default: begin
            state_nxt = ST_SCAN;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_SCAN;
         col_idx  <= 2'd0;
         slot_cnt <= '0;
         cnt      <= '0;
         pat      <= 4'hF;
         row_idx  <= 2'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         col_idx  <= col_nxt;
         slot_cnt <= slot_nxt;
         cnt      <= cnt_nxt;
         pat      <= pat_nxt;
         row_idx  <= ridx_nxt;
`ifdef KEYPAD_AUTOREPEAT_EN
         rep_cnt  <= rep_nxt;
`endif
      end
   end

   // Output registers; clr beats a same-cycle accept for number only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         keyValid <= 1'b0;
         keyCode  <= 4'h0;
         number   <= 32'h0;
      end else begin
         keyValid <= accept;
         if (accept) keyCode <= code;
         if (clr)         number <= 32'h0;
         else if (accept) number <= {number[27:0], code};
      end
   end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with a small keypad model that pulls the
// pressed key's row low whenever that key's column is driven.

module tb_keypad_hex_entry;

   logic        clk;
   logic        rst_n;
   logic [3:0]  rowIn;
   logic [3:0]  colOut;
   logic        clr;
   logic [31:0] number;
   logic [3:0]  keyCode;
   logic        keyValid;

   // Keypad model / manual row override.
   logic        key_dn;
   logic [1:0]  key_r;
   logic [1:0]  key_c;
   logic        manual;
   logic [3:0]  man_rows;

   int n_vec;
   int n_bad;
   int kv_cnt;

   keypad_hex_entry #(
      .SCAN_DIV    (4),
      .DEBOUNCE_CYC(8),
      .REPEAT_CYC  (32)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .rowIn   (rowIn),
      .colOut  (colOut),
      .clr     (clr),
      .number  (number),
      .keyCode (keyCode),
      .keyValid(keyValid)
   );

   assign rowIn = manual ? man_rows :
                  ((key_dn && (colOut[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge, pulses counted here.
   task automatic tick();
      @(posedge clk);
      #1;
      if (keyValid === 1'b1) kv_cnt++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [3:0] exp_col(input int c);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << c);
   endfunction

   // Wait (bounded) until colOut has just switched to the given pattern.
   task automatic wait_col_start(input logic [3:0] pat, input string tag);
      logic [3:0] prev;
      bit         seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         prev = colOut;
         tick();
         if (colOut == pat && prev != pat) seen = 1;
      end
      check_val(tag, {31'd0, seen}, 32'd1);
   endtask

   task automatic press_key(input logic [3:0] code, input int hold);
      int k0;
      k0     = kv_cnt;
      key_r  = code[3:2];
      key_c  = code[1:0];
      key_dn = 1'b1;
      ticks(hold);
      key_dn = 1'b0;
      ticks(20);
      check_val("press_pulses", kv_cnt - k0, 1);
      check_val("press_code", {28'd0, keyCode}, {28'd0, code});
   endtask

   initial begin
      int k0;
      n_vec    = 0;
      n_bad    = 0;
      kv_cnt   = 0;
      rst_n    = 1'b0;
      clr      = 1'b0;
      key_dn   = 1'b0;
      key_r    = 2'd0;
      key_c    = 2'd0;
      manual   = 1'b0;
      man_rows = 4'hF;

      // Reset and idle scan.
      ticks(3);
      rst_n = 1'b1;
      check_val("rst_col", {28'd0, colOut}, 32'h0000000E);
      check_val("rst_num", number, 32'h0);
      check_val("rst_code", {28'd0, keyCode}, 32'h0);
      check_val("rst_kv", {31'd0, keyValid}, 32'h0);
      for (int n = 1; n <= 64; n++) begin
         tick();
         check_val("idle_col", {28'd0, colOut}, {28'd0, exp_col((n / 4) % 4)});
      end
      check_val("idle_kv", kv_cnt, 0);
      check_val("idle_num", number, 32'h0);

      // Single key: row 2, col 1 -> 9.
      press_key(4'h9, 40);
      check_val("key9_num", number, 32'h00000009);

      // Keys 1..9: digit 9 from before and digit 1 fall off the top.
      for (int k = 1; k <= 9; k++) press_key(4'(k), 40);
      check_val("seq_num", number, 32'h23456789);

      // Bounce on row 0 during col 0: enters debounce then drops back to scan.
      manual   = 1'b1;
      man_rows = 4'hF;
      wait_col_start(4'b1110, "bnc_sync");
      k0       = kv_cnt;
      man_rows = 4'b1110;
      ticks(3);
      man_rows = 4'hF;
      tick();
      check_val("bnc_frozen", {28'd0, colOut}, 32'h0000000E);
      ticks(2);
      check_val("bnc_adv", {28'd0, colOut}, 32'h0000000D);
      ticks(4);
      check_val("bnc_scan", {28'd0, colOut}, 32'h0000000B);
      ticks(10);
      check_val("bnc_nokv", kv_cnt - k0, 0);
      check_val("bnc_num", number, 32'h23456789);
      manual = 1'b0;

      // clr on the accept cycle of key 5 (row 1, col 1): accept lands on
      // the 12th edge after col 1's slot starts with the key already down.
      wait_col_start(4'b1101, "clr_sync");
      key_r  = 2'd1;
      key_c  = 2'd1;
      key_dn = 1'b1;
      ticks(11);
      check_val("clr_lat", {31'd0, keyValid}, 32'h0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_val("clr_kv", {31'd0, keyValid}, 32'h1);
      check_val("clr_code", {28'd0, keyCode}, 32'h5);
      check_val("clr_num", number, 32'h0);
      tick();
      check_val("clr_pulse", {31'd0, keyValid}, 32'h0);
      key_dn = 1'b0;
      ticks(20);

      press_key(4'hA, 40);
      check_val("keyA_num", number, 32'h0000000A);

      // Reset during debounce of key 6 (row 1, col 2) with the key held.
      wait_col_start(4'b1011, "rst_sync");
      key_r  = 2'd1;
      key_c  = 2'd2;
      key_dn = 1'b1;
      ticks(6);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_col", {28'd0, colOut}, 32'h0000000E);
      check_val("mid_rst_num", number, 32'h0);
      check_val("mid_rst_code", {28'd0, keyCode}, 32'h0);
      check_val("mid_rst_kv", {31'd0, keyValid}, 32'h0);
      ticks(3);
      rst_n = 1'b1;
      k0    = kv_cnt;
      ticks(40);
      key_dn = 1'b0;
      ticks(20);
      check_val("redet_pulses", kv_cnt - k0, 1);
      check_val("redet_code", {28'd0, keyCode}, 32'h6);
      check_val("redet_num", number, 32'h00000006);

      // clr alone, then key 3 held 100 cycles past its accept.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check_val("clr_only", number, 32'h0);
      key_r  = 2'd0;
      key_c  = 2'd3;
      key_dn = 1'b1;
      k0     = kv_cnt;
      for (int i = 0; i < 80 && kv_cnt == k0; i++) tick();
      check_val("hold_accept", kv_cnt - k0, 1);
      ticks(100);
      key_dn = 1'b0;
      ticks(20);
`ifdef KEYPAD_AUTOREPEAT_EN
      check_val("hold_pulses", kv_cnt - k0, 4);
      check_val("hold_num", number, 32'h00003333);
`else
      check_val("hold_pulses", kv_cnt - k0, 1);
      check_val("hold_num", number, 32'h00000003);
`endif
      check_val("hold_code", {28'd0, keyCode}, 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
